// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiters.
// The counter width helper is only used when WB_ARB_TIMEOUT_EN is defined.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam int MAX_MASTER = 8;
    localparam int IDX_W      = 3;

    // Width of a counter that must be able to hold the value 'cycles'.
    function automatic int timeout_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    // Index of the first set request at or after 'ptr', searching upward and
    // wrapping within 'n' slots; -1 when no request is set.
    function automatic int rr_pick(input logic [MAX_MASTER-1:0] req,
                                   input int                    ptr,
                                   input int                    n);
        int winner;
        int idx;
        winner = -1;
        for (int k = MAX_MASTER - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (req[IDX_W'(idx)]) begin
                    winner = idx;
                end
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_picker.sv
// Combinational round-robin picker: one-hot winner among 'req' starting at 'ptr'.
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [MAX_MASTER-1:0] req_wide;
    int                    winner;

    generate
        for (genvar gi = 0; gi < MAX_MASTER; gi++) begin : g_req
            if (gi < N) begin : g_used
                assign req_wide[gi] = req[gi];
            end else begin : g_pad
                assign req_wide[gi] = 1'b0;
            end
        end
    endgenerate

    assign winner = rr_pick(req_wide, int'(ptr), N);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = (winner == gi);
        end
    endgenerate

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N_MASTER masters share one slave, grant held per cyc tenure.
// Define WB_ARB_TIMEOUT_EN to add the stall watchdog and the ABORT state.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTER       = 4,
    parameter int TAGSIZE        = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst_i,
    input  logic [N_MASTER-1:0]         m_cyc_i,
    input  logic [N_MASTER-1:0]         m_stb_i,
    input  logic [N_MASTER-1:0]         m_we_i,
    input  logic [N_MASTER*32-1:0]      m_adr_i,
    input  logic [N_MASTER*32-1:0]      m_dat_i,
    input  logic [N_MASTER*4-1:0]       m_sel_i,
    input  logic [N_MASTER*TAGSIZE-1:0] m_tag_i,
    output logic [31:0]                 m_dat_o,
    output logic [N_MASTER-1:0]         m_ack_o,
    output logic [N_MASTER-1:0]         m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [31:0]                 s_adr_o,
    output logic [31:0]                 s_dat_o,
    output logic [3:0]                  s_sel_o,
    output logic [TAGSIZE-1:0]          s_tag_o,
    input  logic [31:0]                 s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    output logic [N_MASTER-1:0]         grant_o
);

    localparam int PW = $clog2(N_MASTER);

    arb_state_t          state_reg;
    logic [N_MASTER-1:0] grant_reg;
    logic [PW-1:0]       prio_ptr_reg;
    logic [PW-1:0]       ptr_next;
    logic [N_MASTER-1:0] pick;
    logic                slave_open;
    logic                granted_cyc;

    logic [31:0]         adr_gated [N_MASTER];
    logic [31:0]         dat_gated [N_MASTER];
    logic [3:0]          sel_gated [N_MASTER];
    logic [TAGSIZE-1:0]  tag_gated [N_MASTER];

    rr_picker #(
        .N  (N_MASTER),
        .PW (PW)
    ) u_picker (
        .req   (m_cyc_i),
        .ptr   (prio_ptr_reg),
        .grant (pick)
    );

    // Pointer moves to the slot just past the winner so it has lowest priority next.
    always_comb begin
        ptr_next = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (pick[i]) begin
                ptr_next = (i == N_MASTER - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_gate
            assign adr_gated[gi] = grant_reg[gi] ? m_adr_i[gi*32 +: 32]           : '0;
            assign dat_gated[gi] = grant_reg[gi] ? m_dat_i[gi*32 +: 32]           : '0;
            assign sel_gated[gi] = grant_reg[gi] ? m_sel_i[gi*4 +: 4]             : '0;
            assign tag_gated[gi] = grant_reg[gi] ? m_tag_i[gi*TAGSIZE +: TAGSIZE] : '0;
        end
    endgenerate

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_tag_o = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            s_adr_o = s_adr_o | adr_gated[i];
            s_dat_o = s_dat_o | dat_gated[i];
            s_sel_o = s_sel_o | sel_gated[i];
            s_tag_o = s_tag_o | tag_gated[i];
        end
    end

    // Only GRANT exposes the slave; IDLE and ABORT keep it masked.
    assign slave_open  = (state_reg == GRANT);
    assign granted_cyc = |(m_cyc_i & grant_reg);

    assign s_cyc_o = slave_open & granted_cyc;
    assign s_stb_o = slave_open & (|(m_stb_i & m_cyc_i & grant_reg));
    assign s_we_o  = |(m_we_i & grant_reg);
    assign m_dat_o = s_dat_i;
    assign m_ack_o = slave_open ? (grant_reg & {N_MASTER{s_ack_i}}) : '0;
    assign grant_o = grant_reg;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] to_cnt_reg;
    logic             abort_err_reg;
    logic             stalled;

    assign stalled = s_stb_o & ~s_ack_i & ~s_err_i;
    assign m_err_o = (slave_open ? (grant_reg & {N_MASTER{s_err_i}}) : '0)
                   | (abort_err_reg ? grant_reg : '0);
`else
    assign m_err_o = slave_open ? (grant_reg & {N_MASTER{s_err_i}}) : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            prio_ptr_reg  <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            to_cnt_reg    <= '0;
            abort_err_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|m_cyc_i) begin
                        grant_reg    <= pick;
                        prio_ptr_reg <= ptr_next;
                        state_reg    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!granted_cyc) begin
                        grant_reg  <= '0;
                        state_reg  <= IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                        to_cnt_reg <= '0;
                    // Abort on the edge where the stall count would reach the limit.
                    end else if (stalled && to_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        to_cnt_reg    <= '0;
                        abort_err_reg <= 1'b1;
                        state_reg     <= ABORT;
                    end else if (stalled) begin
                        to_cnt_reg <= to_cnt_reg + CNT_W'(1);
                    end else begin
                        to_cnt_reg <= '0;
                    end
`else
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ABORT: begin
                    abort_err_reg <= 1'b0;
                    if (!granted_cyc) begin
                        grant_reg <= '0;
                        state_reg <= IDLE;
                    end
                end
`endif
                default: begin
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone arbiter that shares one Wishbone slave between N_MASTER requesters, for example several bus masters feeding a single memory or peripheral port. A master keeps its grant for its whole `cyc` tenure, so locked read-modify-write sequences and bursts stay intact. An optional watchdog terminates stalled transfers with an error. The block sits between master ports and one slave, as a lightweight alternative to a full crossbar.

## Interface
Parameters:
- N_MASTER, 4: number of requesting masters (2..8)
- TAGSIZE, 1: width of the Wishbone tag, passed through to the slave
- TIMEOUT_CYCLES, 255: cycles of `stb` without `ack`/`err` before forced error (only used with WB_ARB_TIMEOUT_EN)

Ports (all single clock; the reset is synchronous and active-high):
- clk  in  1  clock; everything samples on the rising edge
- rst_i  in  1  synchronous active-high reset
- m_cyc_i  in  N_MASTER  per-master cycle request
- m_stb_i  in  N_MASTER  per-master strobe
- m_we_i  in  N_MASTER  per-master write enable
- m_adr_i  in  N_MASTER×32  per-master address
- m_dat_i  in  N_MASTER×32  per-master write data
- m_sel_i  in  N_MASTER×4  per-master byte select
- m_tag_i  in  N_MASTER×TAGSIZE  per-master tag
- m_dat_o  out  32  slave read data, broadcast to all masters
- m_ack_o  out  N_MASTER  acknowledge, routed to the granted master only
- m_err_o  out  N_MASTER  error, routed to the granted master only
- s_cyc_o, s_stb_o, s_we_o  out  1  slave control
- s_adr_o  out  32, s_dat_o  out  32, s_sel_o  out  4, s_tag_o  out  TAGSIZE: slave request
- s_dat_i  in  32, s_ack_i  in  1, s_err_i  in  1: slave response
- grant_o  out  N_MASTER  one-hot current grant (status)

## Operation
- States: IDLE, GRANT, and (with timeout) ABORT.
- IDLE
  - If any `m_cyc_i` is set, pick the first requester at or after `prio_ptr`, searching upward and wrapping.
  - Register that one-hot grant and go to GRANT.
  - Set `prio_ptr` = (winner+1) mod N_MASTER.
- GRANT
  - `s_*` outputs are combinational muxes of the granted master's inputs, gated by `grant_o`.
  - `s_ack_i`/`s_err_i` are routed to the granted bit of `m_ack_o`/`m_err_o`; all other bits read 0.
  - When the granted `m_cyc_i` is low, clear the grant and return to IDLE. Slave `cyc` drops in that same cycle because the path is combinational.
- Requests from non-granted masters are held off: they see no `ack`/`err`, and their `stb` never reaches the slave.
- In IDLE all `s_cyc_o`/`s_stb_o` are 0, and `m_ack_o`/`m_err_o` are 0.
- Simultaneous requests: the round-robin order decides the winner, so with continuous requests no master waits more than N_MASTER-1 tenures.
- A master that drops `cyc` in the same cycle as the slave `ack` completes normally.

## Timing
- Reset values:
  - `grant_o` = 0 and state IDLE
  - `prio_ptr` = 0, so master 0 has highest priority after reset
  - all `s_*` control outputs 0, `m_ack_o` = 0, `m_err_o` = 0
  - timeout counter = 0
- Grant latency: a request arriving in IDLE during cycle t puts `s_cyc_o` high in cycle t+1.
- Response path: slave→master `ack`/`err`/data is combinational, with zero added cycles.
- Re-arbitration: after the release cycle there is exactly one IDLE cycle before the next grant, so back-to-back tenures have a 1-cycle gap.
- Reset mid-transfer: the grant is cleared at the next edge and the slave sees `cyc` = 0 from then on. No `ack` or `err` is issued to the aborted master.

## Configuration
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts GRANT cycles in which `s_stb_o`=1 and `s_ack_i`=`s_err_i`=0.
  - It clears on any `ack`/`err` or when leaving GRANT.
  - When the count reaches TIMEOUT_CYCLES, go to ABORT.
- ABORT:
  - For one cycle, force `s_cyc_o`/`s_stb_o` to 0 and assert `m_err_o` for the granted master.
  - Then hold the grant, with the slave still masked, until that master drops `cyc`, then go to IDLE.
  - A late slave `ack` during ABORT is discarded.
- Undefined: there is no counter and no ABORT state, and a stalled slave holds the grant indefinitely.

## Structure
- Package `wb_arb_pkg` holds:
  - the state enum (IDLE, GRANT, ABORT)
  - the localparam for the counter width
  - a `rr_pick` function signature description
- One combinational sub-module, `rr_picker` (inputs: request vector and pointer; output: one-hot winner), reused by other arbiters in the codebase.
- Grant register, pointer, FSM and timeout counter live in the top module.

## Test plan
- Single request: master 2 raises `cyc`/`stb` at t=0, with the slave acking at t=2.
  - `s_cyc_o`=1 at t=1 and `m_ack_o`=4'b0100 at t=2.
  - After master 2 drops `cyc`, `grant_o` = 0 next cycle.
- Round robin: all 4 masters request continuously after reset, each tenure being 1 access.
  - Grant order is 0,1,2,3,0, with a 1-cycle IDLE gap between tenures.
- Tenure lock: master 1 holds `cyc` for 3 accesses while master 0 requests.
  - Master 0 is granted only after master 1 releases.
  - Master 0 sees `ack` = 0 throughout.
- Reset mid-transfer: assert `rst_i` for one cycle while master 3 is granted with `stb` pending.
  - Next cycle: `grant_o` = 0, `s_cyc_o` = 0, `prio_ptr` = 0.
  - A subsequent simultaneous request from masters 0 and 3 grants master 0.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): the slave never acks.
  - `m_err_o` pulses for one cycle 8 cycles after `s_stb_o` rises, and `s_cyc_o` goes to 0 in that cycle.
  - A late `s_ack_i` is not forwarded.
- Timeout disabled: the same stall holds the grant for 1000 cycles, with no `err` and no re-arbitration.
